three_d_prefetcher: RTL and testbench

- Spatial prefetch generator for data laid out as a linear-indexed 3D grid of X_DIM x Y_DIM x Z_DIM elements.
- Index = x + y*X_DIM + z*X_DIM*Y_DIM.
- On each accepted demand address, emits the face-adjacent neighbour indices (up to 6), one per cycle, to the prefetch queue.
- Sits between the demand-miss path and the prefetch request queue.

---
 rtl/three_d_prefetcher.sv | 126 ++++++++++++
 tb/tb_three_d_prefetcher.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/three_d_prefetcher.sv
//==============================================================================
// three_d_prefetcher : face-neighbour prefetch generator for a linear 3D grid.
// Optional macro PREFETCH_WRAP_EN selects toroidal (wrap-around) neighbours.
// Revision: 1.0
//==============================================================================
`default_nettype none

module three_d_prefetcher #(
   parameter int ADDR_WIDTH = 32,
   parameter int X_DIM      = 4,
   parameter int Y_DIM      = 4,
   parameter int Z_DIM      = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  valid_i,
   input  logic [ADDR_WIDTH-1:0] address_i,
   output logic                  ready_o,
   output logic [ADDR_WIDTH-1:0] address_o
);

   // One extra bit so the grid size itself (up to 2**ADDR_WIDTH) is representable.
   localparam int CW = ADDR_WIDTH + 1;

   localparam logic [CW-1:0] XC    = CW'(X_DIM);
   localparam logic [CW-1:0] YC    = CW'(Y_DIM);
   localparam logic [CW-1:0] ZC    = CW'(Z_DIM);
   localparam logic [CW-1:0] XYC   = XC * YC;
   localparam logic [CW-1:0] GRIDC = XYC * ZC;
   localparam logic [CW-1:0] XMAX  = XC - CW'(1);
   localparam logic [CW-1:0] YMAX  = YC - CW'(1);
   localparam logic [CW-1:0] ZMAX  = ZC - CW'(1);

   // Neighbour offsets; modular ADDR_WIDTH arithmetic is exact for in-grid results.
   localparam logic [ADDR_WIDTH-1:0] STEP_X = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] STEP_Y = ADDR_WIDTH'(XC);
   localparam logic [ADDR_WIDTH-1:0] STEP_Z = ADDR_WIDTH'(XYC);
   localparam logic [ADDR_WIDTH-1:0] SPAN_X = ADDR_WIDTH'(XMAX);
   localparam logic [ADDR_WIDTH-1:0] SPAN_Y = ADDR_WIDTH'(XC * YMAX);
   localparam logic [ADDR_WIDTH-1:0] SPAN_Z = ADDR_WIDTH'(XYC * ZMAX);

`ifdef PREFETCH_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic [ADDR_WIDTH-1:0] base_addr;
   logic [CW-1:0]         coord_x;
   logic [CW-1:0]         coord_y;
   logic [CW-1:0]         coord_z;
   logic [5:0]            mask;

   logic [CW-1:0]         addr_ext;
   logic [CW-1:0]         dec_x;
   logic [CW-1:0]         dec_y;
   logic [CW-1:0]         dec_z;
   logic                  in_grid;
   logic [5:0]            load_mask;
   logic [ADDR_WIDTH-1:0] cand;

   always_comb begin
      addr_ext = {1'b0, address_i};
      dec_x    = addr_ext % XC;
      dec_y    = (addr_ext / XC) % YC;
      dec_z    = addr_ext / XYC;
      in_grid  = (addr_ext < GRIDC);
      load_mask = 6'b000000;
      if (in_grid) begin
`ifdef PREFETCH_WRAP_EN
         load_mask = 6'b111111;
`else
         load_mask[0] = (dec_x != '0);
         load_mask[1] = (dec_x != XMAX);
         load_mask[2] = (dec_y != '0);
         load_mask[3] = (dec_y != YMAX);
         load_mask[4] = (dec_z != '0);
         load_mask[5] = (dec_z != ZMAX);
`endif
      end
   end

   // Candidate for the lowest pending direction; wrap terms only fire in toroidal mode.
   always_comb begin
      cand = base_addr;
      casez (mask)
         6'b?????1: cand = (WRAP && coord_x == '0)   ? base_addr + SPAN_X : base_addr - STEP_X;
         6'b????10: cand = (WRAP && coord_x == XMAX) ? base_addr - SPAN_X : base_addr + STEP_X;
         6'b???100: cand = (WRAP && coord_y == '0)   ? base_addr + SPAN_Y : base_addr - STEP_Y;
         6'b??1000: cand = (WRAP && coord_y == YMAX) ? base_addr - SPAN_Y : base_addr + STEP_Y;
         6'b?10000: cand = (WRAP && coord_z == '0)   ? base_addr + SPAN_Z : base_addr - STEP_Z;
         6'b100000: cand = (WRAP && coord_z == ZMAX) ? base_addr - SPAN_Z : base_addr + STEP_Z;
         default:   cand = base_addr;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         ready_o   <= 1'b0;
         address_o <= '0;
         mask      <= '0;
         base_addr <= '0;
         coord_x   <= '0;
         coord_y   <= '0;
         coord_z   <= '0;
      end else begin
         ready_o <= (mask != 6'b000000);
         if (mask != 6'b000000) begin
            address_o <= cand;
         end
         // A new request replaces whatever is left of the current sequence.
         if (valid_i) begin
            mask      <= load_mask;
            base_addr <= address_i;
            coord_x   <= dec_x;
            coord_y   <= dec_y;
            coord_z   <= dec_z;
         end else begin
            mask <= mask & (mask - 6'd1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_three_d_prefetcher.sv
// Directed table-driven bench for three_d_prefetcher on a 4x4x4 grid.
`default_nettype none

module tb_three_d_prefetcher;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        valid_i = 1'b0;
   logic [31:0] address_i = '0;
   logic        ready_o;
   logic [31:0] address_o;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic [31:0]       addr;
      int                n;
      logic [5:0][31:0]  exp;
   } vec_t;

   vec_t vecs[$];

   three_d_prefetcher #(
      .ADDR_WIDTH(32), .X_DIM(4), .Y_DIM(4), .Z_DIM(4)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .valid_i   (valid_i),
      .address_i (address_i),
      .ready_o   (ready_o),
      .address_o (address_o)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [31:0] a, input int n,
                          input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                          input logic [31:0] e3, input logic [31:0] e4, input logic [31:0] e5);
      vec_t v;
      v.addr = a; v.n = n;
      v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
      v.exp[3] = e3; v.exp[4] = e4; v.exp[5] = e5;
      vecs.push_back(v);
   endtask

   // Drive one request, then expect n consecutive pulses followed by silence.
   task automatic run_vec(input vec_t v);
      valid_i = 1'b1; address_i = v.addr;
      @(negedge clock);
      valid_i = 1'b0;
      for (int k = 0; k < v.n; k++) begin
         @(negedge clock);
         check($sformatf("req 0x%0h ready[%0d]", v.addr, k), {31'b0, ready_o}, 32'd1);
         check($sformatf("req 0x%0h addr[%0d]", v.addr, k), address_o, v.exp[k]);
      end
      if (v.n == 0) begin
         for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check($sformatf("req 0x%0h no pulse[%0d]", v.addr, k), {31'b0, ready_o}, 32'd0);
         end
      end else begin
         @(negedge clock);
         check($sformatf("req 0x%0h ready after last", v.addr), {31'b0, ready_o}, 32'd0);
         check($sformatf("req 0x%0h addr hold", v.addr), address_o, v.exp[v.n-1]);
      end
   endtask

   initial begin
      logic [31:0] restart_exp[$];

`ifdef PREFETCH_WRAP_EN
      add_vec(32'h00, 6, 32'h03, 32'h01, 32'h0C, 32'h04, 32'h30, 32'h10);
      add_vec(32'h3F, 6, 32'h3E, 32'h3C, 32'h3B, 32'h33, 32'h2F, 32'h0F);
      add_vec(32'h03, 6, 32'h02, 32'h00, 32'h0F, 32'h07, 32'h33, 32'h13);
      add_vec(32'h15, 6, 32'h14, 32'h16, 32'h11, 32'h19, 32'h05, 32'h25);
      restart_exp = '{32'h14, 32'h16, 32'h03, 32'h01, 32'h0C, 32'h04, 32'h30, 32'h10};
`else
      add_vec(32'h00, 3, 32'h01, 32'h04, 32'h10, 32'h0, 32'h0, 32'h0);
      add_vec(32'h3F, 3, 32'h3E, 32'h3B, 32'h2F, 32'h0, 32'h0, 32'h0);
      add_vec(32'h03, 3, 32'h02, 32'h07, 32'h13, 32'h0, 32'h0, 32'h0);
      add_vec(32'h15, 6, 32'h14, 32'h16, 32'h11, 32'h19, 32'h05, 32'h25);
      add_vec(32'h05, 5, 32'h04, 32'h06, 32'h01, 32'h09, 32'h15, 32'h0);
      restart_exp = '{32'h14, 32'h16, 32'h01, 32'h04, 32'h10};
`endif
      add_vec(32'h2A, 6, 32'h29, 32'h2B, 32'h26, 32'h2E, 32'h1A, 32'h3A);
      add_vec(32'h40, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      add_vec(32'hFFFF_FFFF, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

      // Reset held low for two edges, then released with no request.
      repeat (2) @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check("reset ready", {31'b0, ready_o}, 32'd0);
         check("reset addr", address_o, 32'd0);
      end

      foreach (vecs[i]) run_vec(vecs[i]);

      // Second request accepted at the edge after the first pulse is registered.
      valid_i = 1'b1; address_i = 32'h15;
      @(negedge clock);
      valid_i = 1'b0;
      @(negedge clock);
      check("restart ready[0]", {31'b0, ready_o}, 32'd1);
      check("restart addr[0]", address_o, restart_exp[0]);
      valid_i = 1'b1; address_i = 32'h00;
      @(negedge clock);
      valid_i = 1'b0;
      check("restart ready[1]", {31'b0, ready_o}, 32'd1);
      check("restart addr[1]", address_o, restart_exp[1]);
      for (int k = 2; k < restart_exp.size(); k++) begin
         @(negedge clock);
         check($sformatf("restart ready[%0d]", k), {31'b0, ready_o}, 32'd1);
         check($sformatf("restart addr[%0d]", k), address_o, restart_exp[k]);
      end
      @(negedge clock);
      check("restart ready after last", {31'b0, ready_o}, 32'd0);

      // Reset asserted mid-stream aborts the sequence.
      valid_i = 1'b1; address_i = 32'h15;
      @(negedge clock);
      valid_i = 1'b0;
      @(negedge clock);
      check("midrst ready[0]", {31'b0, ready_o}, 32'd1);
      check("midrst addr[0]", address_o, 32'h14);
      reset = 1'b0;
      @(negedge clock);
      check("midrst ready cleared", {31'b0, ready_o}, 32'd0);
      check("midrst addr cleared", address_o, 32'd0);
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         check($sformatf("midrst quiet[%0d]", k), {31'b0, ready_o}, 32'd0);
      end

      // Reset also overrides a simultaneous request.
      reset = 1'b0; valid_i = 1'b1; address_i = 32'h15;
      @(negedge clock);
      reset = 1'b1; valid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check($sformatf("rst over valid quiet[%0d]", k), {31'b0, ready_o}, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

`default_nettype wire
